csr_spi_master: RTL

- SPI mode-3 master that issues CSR transactions: one address byte, then N data bytes, per CS-low frame.
- Mirrors the protocol of the SPI-slave CSR bank. Used by the self-boot/config sequencer and by board-level test benches to program LUT, operation and timing registers and to poll the status register.
- Converts a command + byte-stream handshake into SCK/MOSI/CS and returns MISO bytes.

---
 rtl/csr_spi_master.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/csr_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : csr_spi_master
// Purpose  : SPI mode-3 master issuing CSR frames (one address byte followed
//            by len+1 data bytes per CS-low frame) from a command + byte-stream
//            handshake, returning each MISO data byte on rd_data/rd_valid.
// Revision : 1.0 - initial release
// ============================================================================
module csr_spi_master #(
   parameter int         CLK_DIV    = 8,     // SCK half-period in clk cycles (8..255)
   parameter int         CS_SETUP   = 4,     // CS falling to first SCK falling
   parameter int         CS_HOLD    = 4,     // last SCK rising to CS rising
   parameter int         CS_IDLE    = 8,     // minimum CS-high time between frames
   parameter logic [7:0] DUMMY_BYTE = 8'h00  // MOSI byte sent in read frames
) (
   input  logic       clk,
   input  logic       rst_n,
   // command handshake
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_len,
   input  logic       cmd_write,
   // write byte stream
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   // read-back byte stream
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   // SPI pins
   output logic       spi_cs,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   // Divider compare points inside one bit period (2*CLK_DIV cycles).
   localparam logic [8:0]  DIV_RISE   = 9'(CLK_DIV);
   localparam logic [8:0]  DIV_LAST   = 9'(2 * CLK_DIV - 1);
   // Terminal counts of the frame-level wait states.
   localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
   localparam logic [15:0] GAP_LAST   = 16'(CS_IDLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   state_t      state;
   logic        miso_meta;
   logic        miso_sync;
   logic        write_op;    // latched cmd_write for the current frame
   logic        addr_phase;  // the byte in flight is the address byte
   logic [8:0]  byte_cnt;    // data bytes still to send; 9 bits so len=255 gives 256
   logic [2:0]  bit_cnt;     // bit index within the current byte
   logic [8:0]  div_cnt;     // position inside the current bit period
   logic [15:0] wait_cnt;    // shared counter for SETUP / HOLD / GAP
   logic [7:0]  tx_shift;    // outgoing byte, MSB presented first
   logic [7:0]  rx_shift;    // incoming byte assembled from synchronized MISO

   // Two-flop synchronizer for the asynchronous MISO input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miso_meta <= 1'b0;
         miso_sync <= 1'b0;
      end else begin
         miso_meta <= spi_miso;
         miso_sync <= miso_meta;
      end
   end

   // Frame sequencer: owns every registered output and the SPI pin timing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         spi_cs     <= 1'b1;
         spi_sck    <= 1'b1;
         spi_mosi   <= 1'b1;
         tx_ready   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= 8'h00;
         write_op   <= 1'b0;
         addr_phase <= 1'b0;
         byte_cnt   <= 9'd0;
         bit_cnt    <= 3'd0;
         div_cnt    <= 9'd0;
         wait_cnt   <= 16'd0;
         tx_shift   <= 8'h00;
         rx_shift   <= 8'h00;
      end else begin
         // Handshake strobes are single-cycle pulses.
         tx_ready <= 1'b0;
         rd_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  // The address is the first byte shifted, so it goes
                  // straight into the shift register.
                  tx_shift   <= cmd_addr;
                  write_op   <= cmd_write;
                  byte_cnt   <= {1'b0, cmd_len} + 9'd1;
                  addr_phase <= 1'b1;
                  busy       <= 1'b1;
                  cmd_ready  <= 1'b0;
                  spi_cs     <= 1'b0;
                  wait_cnt   <= 16'd0;
                  state      <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (wait_cnt == SETUP_LAST) begin
                  wait_cnt <= 16'd0;
                  state    <= ST_LOAD;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end

            ST_LOAD: begin
               div_cnt <= 9'd0;
               bit_cnt <= 3'd0;
               if (addr_phase) begin
                  state <= ST_SHIFT;
               end else if (write_op) begin
                  // Without a tx byte the frame stalls here with SCK high.
                  if (tx_valid) begin
                     tx_shift <= tx_data;
                     tx_ready <= 1'b1;
                     state    <= ST_SHIFT;
                  end
               end else begin
                  tx_shift <= DUMMY_BYTE;
                  state    <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               // Falling edge: present the next MSB on MOSI.
               if (div_cnt == 9'd0) begin
                  spi_sck  <= 1'b0;
                  spi_mosi <= tx_shift[7];
                  tx_shift <= {tx_shift[6:0], 1'b0};
               end
               // Rising edge: the slave samples MOSI, we sample MISO.
               if (div_cnt == DIV_RISE) begin
                  spi_sck  <= 1'b1;
                  rx_shift <= {rx_shift[6:0], miso_sync};
               end
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= 9'd0;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (addr_phase) begin
                        // Address byte carries no read-back data.
                        addr_phase <= 1'b0;
                        state      <= ST_LOAD;
                     end else begin
                        rd_data  <= rx_shift;
                        rd_valid <= 1'b1;
                        byte_cnt <= byte_cnt - 9'd1;
                        if (byte_cnt == 9'd1) begin
                           wait_cnt <= 16'd0;
                           state    <= ST_HOLD;
                        end else begin
                           state <= ST_LOAD;
                        end
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end

            ST_HOLD: begin
               if (wait_cnt == HOLD_LAST) begin
                  spi_cs   <= 1'b1;
                  spi_mosi <= 1'b1;
                  wait_cnt <= 16'd0;
                  state    <= ST_GAP;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end

            ST_GAP: begin
               if (wait_cnt == GAP_LAST) begin
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  wait_cnt  <= 16'd0;
                  state     <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
